alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue.sv | 211 +++++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched ops, wakes operands from the CDB, issues one ready op per cycle.
// Optional ALU_RS_OLDEST_FIRST_EN selects the oldest ready entry instead of the lowest-index one.
module alu_issue_queue #(
  parameter int unsigned RS_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        disp_valid,
  input  logic [2:0]  disp_ins_id,
  input  logic [6:0]  disp_opcode,
  input  logic [2:0]  disp_funct3,
  input  logic [6:0]  disp_funct7,
  input  logic [31:0] disp_imm,
  input  logic [5:0]  disp_shamt,
  input  logic [31:0] disp_pc,
  input  logic        disp_is_compressed,
  input  logic        disp_rs1_rdy,
  input  logic [2:0]  disp_rs1_tag,
  input  logic [31:0] disp_rs1_val,
  input  logic        disp_rs2_rdy,
  input  logic [2:0]  disp_rs2_tag,
  input  logic [31:0] disp_rs2_val,
  output logic        disp_full,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_ins_id,
  input  logic [31:0] cdb_val,
  output logic        have_ins,
  output logic [2:0]  ins_id,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [31:0] imm_val,
  output logic [5:0]  shamt_val,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] request_PC,
  output logic        is_compressed_ins
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned IDX_W = $clog2(RS_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0] ins_id;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [5:0]      shamt;
    logic [XLEN-1:0] pc;
    logic            is_c;
    logic            rs1_rdy;
    logic [ID_W-1:0] rs1_tag;
    logic [XLEN-1:0] rs1_val;
    logic            rs2_rdy;
    logic [ID_W-1:0] rs2_tag;
    logic [XLEN-1:0] rs2_val;
  } rs_entry_t;

  rs_entry_t           ent [RS_DEPTH];
  rs_entry_t           new_ent;
  logic [RS_DEPTH-1:0] valid;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic                accept;

  assign disp_full = &valid;
  assign accept    = disp_valid && !disp_full;

  // Incoming entry, with same-cycle CDB bypass on each operand
  always_comb begin
    new_ent         = '0;
    new_ent.ins_id  = disp_ins_id;
    new_ent.opcode  = disp_opcode;
    new_ent.funct3  = disp_funct3;
    new_ent.funct7  = disp_funct7;
    new_ent.imm     = disp_imm;
    new_ent.shamt   = disp_shamt;
    new_ent.pc      = disp_pc;
    new_ent.is_c    = disp_is_compressed;
    new_ent.rs1_rdy = disp_rs1_rdy;
    new_ent.rs1_tag = disp_rs1_tag;
    new_ent.rs1_val = disp_rs1_val;
    new_ent.rs2_rdy = disp_rs2_rdy;
    new_ent.rs2_tag = disp_rs2_tag;
    new_ent.rs2_val = disp_rs2_val;
    if (!disp_rs1_rdy && cdb_valid && (disp_rs1_tag == cdb_ins_id)) begin
      new_ent.rs1_rdy = 1'b1;
      new_ent.rs1_val = cdb_val;
    end
    if (!disp_rs2_rdy && cdb_valid && (disp_rs2_tag == cdb_ins_id)) begin
      new_ent.rs2_rdy = 1'b1;
      new_ent.rs2_val = cdb_val;
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef ALU_RS_OLDEST_FIRST_EN
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(RS_DEPTH - 1);

  logic [IDX_W-1:0] age [RS_DEPTH];
  logic [IDX_W-1:0] best_age;

  // Oldest ready entry wins; strict compare keeps ties on the lowest index
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid[i] && ent[i].rs1_rdy && ent[i].rs2_rdy && (!sel_found || (age[i] > best_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
    end else if (rdy_in && !flush_pipline && accept) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (IDX_W'(i) == free_idx) age[i] <= '0;
        else if (valid[i] && (age[i] != AGE_MAX)) age[i] <= age[i] + IDX_W'(1);
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid[i] && ent[i].rs1_rdy && ent[i].rs2_rdy && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // Entry storage, wakeup, issue and dispatch; everything freezes while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid             <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
      have_ins          <= 1'b0;
      ins_id            <= '0;
      rs1_val           <= '0;
      rs2_val           <= '0;
      imm_val           <= '0;
      shamt_val         <= '0;
      opcode            <= '0;
      funct3            <= '0;
      funct7            <= '0;
      request_PC        <= '0;
      is_compressed_ins <= 1'b0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        valid    <= '0;
        have_ins <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (valid[i] && cdb_valid && !ent[i].rs1_rdy && (ent[i].rs1_tag == cdb_ins_id)) begin
            ent[i].rs1_rdy <= 1'b1;
            ent[i].rs1_val <= cdb_val;
          end
          if (valid[i] && cdb_valid && !ent[i].rs2_rdy && (ent[i].rs2_tag == cdb_ins_id)) begin
            ent[i].rs2_rdy <= 1'b1;
            ent[i].rs2_val <= cdb_val;
          end
        end
        if (sel_found) begin
          valid[sel_idx]    <= 1'b0;
          have_ins          <= 1'b1;
          ins_id            <= ent[sel_idx].ins_id;
          rs1_val           <= ent[sel_idx].rs1_val;
          rs2_val           <= ent[sel_idx].rs2_val;
          imm_val           <= ent[sel_idx].imm;
          shamt_val         <= ent[sel_idx].shamt;
          opcode            <= ent[sel_idx].opcode;
          funct3            <= ent[sel_idx].funct3;
          funct7            <= ent[sel_idx].funct7;
          request_PC        <= ent[sel_idx].pc;
          is_compressed_ins <= ent[sel_idx].is_c;
        end else begin
          have_ins <= 1'b0;
        end
        if (accept && free_found) begin
          valid[free_idx] <= 1'b1;
          ent[free_idx]   <= new_ent;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed dispatch/wakeup/flush vectors, issues checked by a monitor.
module tb_alu_issue_queue;

  logic        clk_in, rst_in, rdy_in, flush_pipline;
  logic        disp_valid;
  logic [2:0]  disp_ins_id;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_funct3;
  logic [6:0]  disp_funct7;
  logic [31:0] disp_imm;
  logic [5:0]  disp_shamt;
  logic [31:0] disp_pc;
  logic        disp_is_compressed;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [2:0]  disp_rs1_tag, disp_rs2_tag;
  logic [31:0] disp_rs1_val, disp_rs2_val;
  logic        disp_full;
  logic        cdb_valid;
  logic [2:0]  cdb_ins_id;
  logic [31:0] cdb_val;
  logic        have_ins;
  logic [2:0]  ins_id;
  logic [31:0] rs1_val, rs2_val, imm_val;
  logic [5:0]  shamt_val;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] request_PC;
  logic        is_compressed_ins;

  alu_issue_queue #(.RS_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .disp_valid(disp_valid), .disp_ins_id(disp_ins_id), .disp_opcode(disp_opcode),
    .disp_funct3(disp_funct3), .disp_funct7(disp_funct7), .disp_imm(disp_imm),
    .disp_shamt(disp_shamt), .disp_pc(disp_pc), .disp_is_compressed(disp_is_compressed),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_val(disp_rs1_val),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_val(disp_rs2_val),
    .disp_full(disp_full), .cdb_valid(cdb_valid), .cdb_ins_id(cdb_ins_id), .cdb_val(cdb_val),
    .have_ins(have_ins), .ins_id(ins_id), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm_val(imm_val), .shamt_val(shamt_val), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .request_PC(request_PC), .is_compressed_ins(is_compressed_ins)
  );

  typedef struct {
    logic [2:0]  id;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic upd = 1'b0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    upd <= rdy_in;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every fresh issue strobe must match the head of the scoreboard
  always @(negedge clk_in) begin
    if (rst_in && upd && have_ins) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got ins_id=%0d at cycle %0d, expected no issue", ins_id, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_id", 32'(ins_id), 32'(e.id));
        chk("issue_rs1", rs1_val, e.r1);
        chk("issue_rs2", rs2_val, e.r2);
        chk("issue_imm", imm_val, e.imm);
        chk("issue_pc", request_PC, e.pc);
        if (e.cyc >= 0) chk("issue_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push(input logic [2:0] id, input logic [31:0] r1, input logic [31:0] imm, input int c);
    exp_t e;
    e.id  = id;
    e.r1  = r1;
    e.r2  = 32'h100 + 32'(id);
    e.imm = imm;
    e.pc  = 32'h1000 + 32'(id) * 4;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic disp(input logic [2:0] id, input logic r1, input logic [2:0] t1,
                      input logic [31:0] v1, input logic [31:0] imm);
    disp_valid         = 1'b1;
    disp_ins_id        = id;
    disp_opcode        = 7'h13;
    disp_funct3        = 3'd0;
    disp_funct7        = 7'd0;
    disp_imm           = imm;
    disp_shamt         = 6'(id);
    disp_pc            = 32'h1000 + 32'(id) * 4;
    disp_is_compressed = 1'b0;
    disp_rs1_rdy       = r1;
    disp_rs1_tag       = t1;
    disp_rs1_val       = v1;
    disp_rs2_rdy       = 1'b1;
    disp_rs2_tag       = 3'd0;
    disp_rs2_val       = 32'h100 + 32'(id);
    cycle();
  endtask

  task automatic cdb(input logic [2:0] id, input logic [31:0] v);
    cdb_valid  = 1'b1;
    cdb_ins_id = id;
    cdb_val    = v;
    cycle();
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_pipline = 1'b0;
    disp_valid = 1'b0; disp_ins_id = '0; disp_opcode = '0; disp_funct3 = '0; disp_funct7 = '0;
    disp_imm = '0; disp_shamt = '0; disp_pc = '0; disp_is_compressed = 1'b0;
    disp_rs1_rdy = 1'b0; disp_rs1_tag = '0; disp_rs1_val = '0;
    disp_rs2_rdy = 1'b0; disp_rs2_tag = '0; disp_rs2_val = '0;
    cdb_valid = 1'b0; cdb_ins_id = '0; cdb_val = '0;

    // Reset with dispatches pending
    for (int k = 0; k < 4; k++) disp(3'(k), 1'b1, 3'd0, 32'h55, 32'h1);
    chk("rst_have_ins", 32'(have_ins), 32'd0);
    rst_in = 1'b1;
    cycle();
    chk("rst_disp_full", 32'(disp_full), 32'd0);
    chk("rst_have_ins_rel", 32'(have_ins), 32'd0);
    chk("rst_ins_id", 32'(ins_id), 32'd0);
    chk("rst_rs1", rs1_val, 32'd0);
    chk("rst_rs2", rs2_val, 32'd0);
    chk("rst_imm", imm_val, 32'd0);
    chk("rst_pc", request_PC, 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    idle(2);
    chk("rst_idle_have_ins", 32'(have_ins), 32'd0);

    // Ready ADDI issues one edge after dispatch; then freeze holds the outputs
    push(3'd2, 32'd5, 32'd7, cyc + 2);
    disp(3'd2, 1'b1, 3'd0, 32'd5, 32'd7);
    chk("addi_not_yet", 32'(have_ins), 32'd0);
    cycle();
    rdy_in = 1'b0;
    idle(2);
    chk("freeze_have_ins", 32'(have_ins), 32'd1);
    chk("freeze_ins_id", 32'(ins_id), 32'd2);
    chk("freeze_imm", imm_val, 32'd7);
    rdy_in = 1'b1;
    cycle();
    chk("after_freeze_have_ins", 32'(have_ins), 32'd0);

    // Wakeup next cycle, then same-cycle bypass
    push(3'd1, 32'h10, 32'd0, cyc + 3);
    disp(3'd1, 1'b0, 3'd4, 32'd0, 32'd0);
    cdb(3'd4, 32'h10);
    chk("wakeup_not_yet", 32'(have_ins), 32'd0);
    cycle();
    cdb_valid = 1'b1; cdb_ins_id = 3'd5; cdb_val = 32'h20;
    push(3'd3, 32'h20, 32'd0, cyc + 2);
    disp(3'd3, 1'b0, 3'd5, 32'd0, 32'd0);
    idle(2);

    // Fill, drop a fifth dispatch, drain via wakeups
    for (int k = 0; k < 4; k++) disp(3'(k), 1'b0, 3'(4 + k), 32'd0, 32'd0);
    chk("full_after_fill", 32'(disp_full), 32'd1);
    disp(3'd4, 1'b1, 3'd0, 32'h99, 32'd0);
    chk("full_after_drop", 32'(disp_full), 32'd1);
    push(3'd3, 32'h77, 32'd0, cyc + 2);
    cdb(3'd7, 32'h77);
    chk("full_after_wake", 32'(disp_full), 32'd1);
    cycle();
    chk("not_full_after_issue", 32'(disp_full), 32'd0);
    push(3'd0, 32'h44, 32'd0, cyc + 2);
    cdb(3'd4, 32'h44);
    push(3'd1, 32'h45, 32'd0, cyc + 2);
    cdb(3'd5, 32'h45);
    push(3'd2, 32'h46, 32'd0, cyc + 2);
    cdb(3'd6, 32'h46);
    idle(3);

    // Older entry in slot 2, younger in slot 0, woken together
    disp(3'd5, 1'b0, 3'd1, 32'd0, 32'd0);
    disp(3'd6, 1'b0, 3'd3, 32'd0, 32'd0);
    disp(3'd7, 1'b0, 3'd2, 32'd0, 32'd0);
    push(3'd5, 32'h11, 32'd0, cyc + 2);
    cdb(3'd1, 32'h11);
    cycle();
    disp(3'd0, 1'b0, 3'd2, 32'd0, 32'd0);
`ifdef ALU_RS_OLDEST_FIRST_EN
    push(3'd7, 32'h22, 32'd0, cyc + 2);
    push(3'd0, 32'h22, 32'd0, cyc + 3);
`else
    push(3'd0, 32'h22, 32'd0, cyc + 2);
    push(3'd7, 32'h22, 32'd0, cyc + 3);
`endif
    cdb(3'd2, 32'h22);
    idle(2);
    push(3'd6, 32'h33, 32'd0, cyc + 2);
    cdb(3'd3, 32'h33);
    idle(2);

    // Flush held off by rdy_in, then applied; nothing may issue afterwards
    disp(3'd1, 1'b0, 3'd5, 32'd0, 32'd0);
    disp(3'd2, 1'b0, 3'd6, 32'd0, 32'd0);
    disp(3'd3, 1'b0, 3'd7, 32'd0, 32'd0);
    rdy_in = 1'b0;
    flush_pipline = 1'b1;
    disp(3'd4, 1'b1, 3'd0, 32'h9, 32'd0);
    cycle();
    chk("frozen_disp_full", 32'(disp_full), 32'd0);
    chk("frozen_have_ins", 32'(have_ins), 32'd0);
    rdy_in = 1'b1;
    disp(3'd4, 1'b1, 3'd0, 32'h9, 32'd0);
    flush_pipline = 1'b0;
    chk("flush_have_ins", 32'(have_ins), 32'd0);
    cdb(3'd5, 32'h50);
    cdb(3'd6, 32'h60);
    cdb(3'd7, 32'h70);
    idle(2);
    chk("flush_no_issue", 32'(have_ins), 32'd0);
    push(3'd4, 32'h9, 32'd3, cyc + 2);
    disp(3'd4, 1'b1, 3'd0, 32'h9, 32'd3);
    idle(3);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
